// File: rtl/crc15_d83.sv
// CAN 2.0 CRC-15 over an 83-bit frame prefix, computed with a single unrolled XOR network.
// Latency is 1 cycle from i_valid to o_valid, with one frame accepted per cycle; there is no backpressure.
// Defining CRC15_D83_CHECK_EN adds i_crc_rx and o_crc_ok, which compare the result against a received CRC field.
module crc15_d83 #(
  parameter logic [14:0] CRC_POLY = 15'h4599,
  parameter logic [14:0] CRC_INIT = 15'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [82:0] din,
`ifdef CRC15_D83_CHECK_EN
  input  logic [14:0] i_crc_rx,
  output logic        o_crc_ok,
`endif
  output logic        o_valid,
  output logic [14:0] o_crc
);

  localparam int DW = 83;
  localparam int CW = 15;

  // These functions are only used at elaboration, to build the XOR masks from the serial recurrence.
  function automatic logic [CW-1:0] serial_crc(input logic [DW-1:0] d, input logic [CW-1:0] init);
    logic [CW-1:0] c;
    logic          nxt;
    c = init;
    for (int k = DW - 1; k >= 0; k--) begin
      nxt = d[k] ^ c[CW-1];
      c   = {c[CW-2:0], 1'b0};
      if (nxt) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

  function automatic logic [CW*DW-1:0] gen_masks();
    logic [CW*DW-1:0] m;
    logic [DW-1:0]    e;
    logic [CW-1:0]    c;
    m = '0;
    for (int k = 0; k < DW; k++) begin
      e = '0;
      e[k] = 1'b1;
      c = serial_crc(e, '0);
      for (int j = 0; j < CW; j++) m[j*DW + k] = c[j];
    end
    return m;
  endfunction

  // Bit j of the CRC is the parity of din under mask j, XORed with the preset's contribution.
  localparam logic [CW*DW-1:0] MASKS     = gen_masks();
  localparam logic [CW-1:0]    INIT_TERM = serial_crc('0, CRC_INIT);

  logic [CW-1:0] crc_next;

  always_comb begin
    crc_next = '0;
    for (int j = 0; j < CW; j++) begin
      crc_next[j] = (^(din & MASKS[j*DW +: DW])) ^ INIT_TERM[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_crc   <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) o_crc <= crc_next;
    end
  end

`ifdef CRC15_D83_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_crc_ok <= 1'b0;
    end else if (i_valid) begin
      o_crc_ok <= (crc_next == i_crc_rx);
    end
  end
`endif

endmodule

// File: tb/tb_crc15_d83.sv
// Scoreboard bench for crc15_d83: the driver queues expected CRCs and the negedge monitor checks them.
// The reference model is polynomial long division of din*x^15 by the generator.
module tb_crc15_d83;

  localparam logic [14:0] POLY = 15'h4599;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [82:0] din = '0;
  logic        o_valid;
  logic [14:0] o_crc;
`ifdef CRC15_D83_CHECK_EN
  logic [14:0] i_crc_rx = '0;
  logic        o_crc_ok;
  logic        ok_q[$];
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];
  logic [14:0] last_crc = '0;

  crc15_d83 dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .din      (din),
`ifdef CRC15_D83_CHECK_EN
    .i_crc_rx (i_crc_rx),
    .o_crc_ok (o_crc_ok),
`endif
    .o_valid  (o_valid),
    .o_crc    (o_crc)
  );

  always #5 clk = ~clk;

  // Remainder of din(x)*x^15 mod G(x), with G = x^15 + POLY.
  function automatic logic [14:0] model(input logic [82:0] d);
    logic [97:0] r;
    logic [97:0] g;
    r = {d, 15'b0};
    for (int i = 97; i >= 15; i--) begin
      if (r[i]) begin
        g = {83'b1, POLY};
        r = r ^ (g << (i - 15));
      end
    end
    return r[14:0];
  endfunction

  function automatic logic [82:0] rnd83();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[82:0];
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_valid: got o_valid=1 with crc %h, expected no result", o_crc);
          last_crc = o_crc;
        end else begin
          last_crc = exp_q.pop_front();
          check("crc", o_crc, last_crc);
`ifdef CRC15_D83_CHECK_EN
          if (ok_q.size() != 0) check("crc_ok", {14'b0, o_crc_ok}, {14'b0, ok_q.pop_front()});
`endif
        end
        obs_q.push_back(o_crc);
      end else begin
        check("hold", o_crc, last_crc);
      end
    end
  end

  task automatic drive(input logic [82:0] d, input logic [14:0] e, input logic [14:0] rx);
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    din     = d;
    exp_q.push_back(e);
`ifdef CRC15_D83_CHECK_EN
    i_crc_rx = rx;
    ok_q.push_back(rx == e);
`else
    if (rx == 15'h7fff) din = d;
`endif
  endtask

  task automatic send(input logic [82:0] d);
    logic [14:0] e;
    e = model(d);
    drive(d, e, ($urandom_range(0, 1) != 0) ? e : 15'($urandom()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      din     = rnd83();
    end
  endtask

  task automatic flush_sb();
    exp_q.delete();
    obs_q.delete();
`ifdef CRC15_D83_CHECK_EN
    ok_q.delete();
`endif
    last_crc = '0;
  endtask

  logic [82:0] frame_req;
  logic [82:0] frame_rsp;
  logic [82:0] a;
  logic [82:0] b;

  initial begin
    // Each frame is SOF, then the 11-bit ID, RTR, IDE, r0, DLC=8 and 8 data bytes.
    frame_req = {1'b0, 11'h7DF, 1'b0, 1'b0, 1'b0, 4'h8, 64'h02010C5555555555};
    frame_rsp = {1'b0, 11'h7E8, 1'b0, 1'b0, 1'b0, 4'h8, 64'h04410C1AF8AAAAAA};

    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    idle(2);

    // Asynchronous reset mid-cycle while a result is showing.
    drive(83'h1, 15'h4599, 15'h4599);
    @(posedge clk);
    #1 i_valid = 1'b0;
    #2 rst = 1'b1;
    flush_sb();
    #1;
    check("async_rst_crc", o_crc, 15'h0000);
    check("async_rst_valid", {14'b0, o_valid}, 15'h0000);
    @(posedge clk);
    #3 rst = 1'b0;
    idle(3);

    // Single-bit vectors, back to back.
    drive(83'h1, 15'h4599, 15'h4599);
    drive(83'h2, 15'h4EAB, 15'h0000);
    drive(83'h3, 15'h0B32, 15'h0B32);
    drive(83'h0, 15'h0000, 15'h0001);
    idle(3);

`ifdef CRC15_D83_CHECK_EN
    drive(83'h1, 15'h4599, 15'h4599);
    drive(83'h1, 15'h4599, 15'h4598);
    idle(2);
`endif

    // Two OBD2 frames on consecutive cycles.
    send(frame_req);
    send(frame_rsp);
    idle(3);

    // Random traffic with gaps.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(rnd83());
    end
    idle(3);

    // Linearity measured on the DUT's own outputs.
    for (int p = 0; p < 20; p++) begin
      a = rnd83();
      b = rnd83();
      obs_q.delete();
      send(a);
      send(b);
      send(a ^ b);
      idle(3);
      if (obs_q.size() == 3) begin
        check("linearity", obs_q[0] ^ obs_q[1], obs_q[2]);
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL linearity_count: got %0d results, expected 3", obs_q.size());
      end
    end

    // Reset on the same cycle as i_valid: that result must be dropped.
    send(rnd83());
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    din     = rnd83();
    rst     = 1'b1;
    flush_sb();
    @(posedge clk);
    #1;
    rst     = 1'b0;
    i_valid = 1'b0;
    check("rst_drop_valid", {14'b0, o_valid}, 15'h0000);
    check("rst_drop_crc", o_crc, 15'h0000);
    idle(3);

    send(rnd83());
    idle(3);
    check("drain", 15'(exp_q.size()), 15'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no completion, expected finish before 5000000");
    $fatal(1, "timeout");
  end

endmodule
